// File: rtl/nice_icb_mem_responder.sv
// +----------------------------------------------------------------------------+
// | nice_icb_mem_responder: ICB memory slave with big-endian byte RAM,        |
// | fixed-latency in-order responses and credit-limited outstanding count.    |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module nice_icb_mem_responder #(
  parameter int MEM_BYTES   = 4096,
  parameter int RSP_LAT     = 1,
  parameter int OUTSTANDING = 2
) (
  input  logic        nice_clk,
  input  logic        nice_rst,
  input  logic        nice_icb_cmd_valid,
  output logic        nice_icb_cmd_ready,
  input  logic [31:0] nice_icb_cmd_addr,
  input  logic        nice_icb_cmd_read,
  input  logic [31:0] nice_icb_cmd_wdata,
  input  logic [1:0]  nice_icb_cmd_size,
  output logic        nice_icb_rsp_valid,
  input  logic        nice_icb_rsp_ready,
  output logic [31:0] nice_icb_rsp_rdata,
  output logic        nice_icb_rsp_err,
  input  logic        bd_we,
  input  logic [31:0] bd_addr,
  input  logic [7:0]  bd_wdata
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic [7:0]    mem [MEM_BYTES];
  logic [CW-1:0] credit;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [32:0]   fifo_mem [OUTSTANDING];
  logic          accept;
  logic          pop;
  logic          push;
  logic [2:0]    nbytes;
  logic          misaligned;
  logic          out_of_range;
  logic          cmd_err;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [31:0]   rd_word;
  rsp_t          acc_ent;
  rsp_t          fifo_in;

  assign nice_icb_cmd_ready = !nice_rst && (credit < CW'(OUTSTANDING));
  assign accept             = nice_icb_cmd_valid && nice_icb_cmd_ready;

  always_comb begin
    nbytes     = 3'd1;
    misaligned = 1'b0;
    case (nice_icb_cmd_size)
      2'd1: begin
        nbytes     = 3'd2;
        misaligned = nice_icb_cmd_addr[0];
      end
      2'd2: begin
        nbytes     = 3'd4;
        misaligned = |nice_icb_cmd_addr[1:0];
      end
      default: nbytes = 3'd1;
    endcase
  end

  // 33-bit sum so addresses near 2^32 cannot wrap back into range
  assign out_of_range = ({1'b0, nice_icb_cmd_addr} + {30'd0, nbytes}) > 33'(MEM_BYTES);
  assign cmd_err      = (nice_icb_cmd_size == 2'd3) || misaligned || out_of_range;

  assign a0 = nice_icb_cmd_addr[AW-1:0];
  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);

  always_comb begin
    rd_word = 32'h0;
    if (nice_icb_cmd_read && !cmd_err) begin
      case (nice_icb_cmd_size)
        2'd0:    rd_word = {24'h0, mem[a0]};
        2'd1:    rd_word = {16'h0, mem[a0], mem[a1]};
        2'd2:    rd_word = {mem[a0], mem[a1], mem[a2], mem[a3]};
        default: rd_word = 32'h0;
      endcase
    end
  end

  // ICB write is placed after the backdoor so it wins on a same-byte collision
  always_ff @(posedge nice_clk) begin
    if (bd_we && (bd_addr < 32'(MEM_BYTES))) begin
      mem[bd_addr[AW-1:0]] <= bd_wdata;
    end
    if (accept && !nice_icb_cmd_read && !cmd_err) begin
      case (nice_icb_cmd_size)
        2'd0: mem[a0] <= nice_icb_cmd_wdata[7:0];
        2'd1: begin
          mem[a0] <= nice_icb_cmd_wdata[15:8];
          mem[a1] <= nice_icb_cmd_wdata[7:0];
        end
        2'd2: begin
          mem[a0] <= nice_icb_cmd_wdata[31:24];
          mem[a1] <= nice_icb_cmd_wdata[23:16];
          mem[a2] <= nice_icb_cmd_wdata[15:8];
          mem[a3] <= nice_icb_cmd_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  assign acc_ent = '{valid: accept, err: cmd_err, data: rd_word};

  // The FIFO write itself is the final latency stage
  generate
    if (RSP_LAT == 1) begin : g_no_pipe
      assign fifo_in = acc_ent;
    end else begin : g_pipe
      rsp_t pipe [RSP_LAT-1];
      always_ff @(posedge nice_clk) begin
        if (nice_rst) begin
          for (int i = 0; i < RSP_LAT - 1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= acc_ent;
          for (int i = 1; i < RSP_LAT - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign fifo_in = pipe[RSP_LAT-2];
    end
  endgenerate

  assign push               = fifo_in.valid;
  assign nice_icb_rsp_valid = (count != '0);
  assign pop                = nice_icb_rsp_valid && nice_icb_rsp_ready;
  assign {nice_icb_rsp_err, nice_icb_rsp_rdata} = nice_icb_rsp_valid ? fifo_mem[rd_ptr] : 33'h0;

  always_ff @(posedge nice_clk) begin
    if (push) fifo_mem[wr_ptr] <= {fifo_in.err, fifo_in.data};
  end

  always_ff @(posedge nice_clk) begin
    if (nice_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      credit <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(OUTSTANDING - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(OUTSTANDING - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      case ({accept, pop})
        2'b10:   credit <= credit + CW'(1);
        2'b01:   credit <= credit - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
